// File: rtl/player_ctrl_if.sv
// Scan-position, control and status bundle for the player controller.
// The slave modport is the controller's view; master is the driver/observer side.
interface player_ctrl_if;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ctrl_up;
    logic        ctrl_down;
    logic        ctrl_left;
    logic        ctrl_right;
    logic        ctrl_slow;
    logic        collision;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [2:0]  lives;
    logic [1:0]  state;
    logic        game_over;
    logic [10:0] sprite_addr;
    logic        sprite_sel;
    logic        player_on;

    modport slave (
        input  x, y, ctrl_up, ctrl_down, ctrl_left, ctrl_right, ctrl_slow, collision,
        output player_x, player_y, lives, state, game_over, sprite_addr, sprite_sel, player_on
    );

    modport master (
        output x, y, ctrl_up, ctrl_down, ctrl_left, ctrl_right, ctrl_slow, collision,
        input  player_x, player_y, lives, state, game_over, sprite_addr, sprite_sel, player_on
    );
endinterface

// File: rtl/player_ctrl.sv
// Player ship controller: tick-paced movement, lives/invulnerability FSM and sprite box lookup.
// Optional macro PLAYER_BLINK_EN blinks the sprite while invulnerable.
module player_ctrl #(
    parameter int FIELD_W      = 384,
    parameter int FIELD_H      = 448,
    parameter int START_X      = 192,
    parameter int START_Y      = 400,
    parameter int TICK_DIV     = 2000000,
    parameter int SPEED_FAST   = 2,
    parameter int SPEED_SLOW   = 1,
    parameter int SPR_W        = 32,
    parameter int SPR_H        = 48,
    parameter int LIVES        = 3,
    parameter int INVULN_TICKS = 120
) (
    input logic          clk,
    input logic          reset,
    player_ctrl_if.slave bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'b00,
        ST_INVULN = 2'b01,
        ST_DEAD   = 2'b10
    } state_t;

    localparam logic signed [10:0] X_LO  = 11'(1 - SPR_W / 2);
    localparam logic signed [10:0] X_HI  = 11'(SPR_W / 2);
    localparam logic signed [10:0] Y_LO  = 11'(1 - SPR_H / 2);
    localparam logic signed [10:0] Y_HI  = 11'(SPR_H / 2);
    localparam logic [10:0]        X_MAX = 11'(FIELD_W - 1);
    localparam logic [10:0]        Y_MAX = 11'(FIELD_H - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [9:0]    player_x_q, player_x_d;
    logic [9:0]    player_y_q, player_y_d;
    logic [2:0]    lives_q, lives_d;
    logic [7:0]    inv_cnt_q, inv_cnt_d;
    state_t        state_q, state_d;
    logic          game_over_q, game_over_d;
    logic          sprite_sel_q, sprite_sel_d;

    logic          tick_s;
    logic [10:0]   step_s;
    logic [10:0]   px_s, py_s, inc_x_s, dec_x_s, inc_y_s, dec_y_s;
    logic [10:0]   next_x_s, next_y_s;
    logic signed [10:0] dx_s, dy_s;
    logic [10:0]   ox_s, oy_s;
    logic          in_box_s, blink_mask_s;

    // Movement tick divider
    always_comb begin
        tick_s = (tick_cnt_q == TW'(TICK_DIV - 1));
        if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    // Saturating candidate position for this tick; bit 10 of a difference flags underflow
    always_comb begin
        step_s  = bus.ctrl_slow ? 11'(SPEED_SLOW) : 11'(SPEED_FAST);
        px_s    = {1'b0, player_x_q};
        py_s    = {1'b0, player_y_q};
        inc_x_s = px_s + step_s;
        dec_x_s = px_s - step_s;
        inc_y_s = py_s + step_s;
        dec_y_s = py_s - step_s;
        if (bus.ctrl_left && !bus.ctrl_right) begin
            next_x_s = dec_x_s[10] ? 11'd0 : dec_x_s;
        end else if (bus.ctrl_right && !bus.ctrl_left) begin
            next_x_s = (inc_x_s > X_MAX) ? X_MAX : inc_x_s;
        end else begin
            next_x_s = px_s;
        end
        if (bus.ctrl_up && !bus.ctrl_down) begin
            next_y_s = dec_y_s[10] ? 11'd0 : dec_y_s;
        end else if (bus.ctrl_down && !bus.ctrl_up) begin
            next_y_s = (inc_y_s > Y_MAX) ? Y_MAX : inc_y_s;
        end else begin
            next_y_s = py_s;
        end
    end

    // Lives / invulnerability FSM and position update
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        inv_cnt_d  = inv_cnt_q;
        player_x_d = player_x_q;
        player_y_d = player_y_q;
        case (state_q)
            ST_ALIVE: begin
                if (bus.collision) begin
                    if (lives_q == 3'd1) begin
                        state_d = ST_DEAD;
                        lives_d = 3'd0;
                    end else begin
                        state_d   = ST_INVULN;
                        lives_d   = lives_q - 3'd1;
                        inv_cnt_d = 8'(INVULN_TICKS);
                    end
                end else begin
                    state_d = ST_ALIVE;
                end
            end
            ST_INVULN: begin
                if (tick_s) begin
                    if (inv_cnt_q <= 8'd1) begin
                        state_d   = ST_ALIVE;
                        inv_cnt_d = 8'd0;
                    end else begin
                        inv_cnt_d = inv_cnt_q - 8'd1;
                    end
                end else begin
                    inv_cnt_d = inv_cnt_q;
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_DEAD;
                lives_d = 3'd0;
            end
        endcase
        // A hit on a tick edge still lets that tick's move land
        if (tick_s && (state_q != ST_DEAD)) begin
            player_x_d = next_x_s[9:0];
            player_y_d = next_y_s[9:0];
        end else begin
            player_x_d = player_x_q;
            player_y_d = player_y_q;
        end
        game_over_d  = (state_d == ST_DEAD);
        sprite_sel_d = (state_d == ST_INVULN);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            player_x_q   <= 10'(START_X);
            player_y_q   <= 10'(START_Y);
            lives_q      <= 3'(LIVES);
            inv_cnt_q    <= 8'd0;
            state_q      <= ST_ALIVE;
            game_over_q  <= 1'b0;
            sprite_sel_q <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            player_x_q   <= player_x_d;
            player_y_q   <= player_y_d;
            lives_q      <= lives_d;
            inv_cnt_q    <= inv_cnt_d;
            state_q      <= state_d;
            game_over_q  <= game_over_d;
            sprite_sel_q <= sprite_sel_d;
        end
    end

    // Sprite box test, signed so boxes near the field edge do not wrap
    always_comb begin
        dx_s     = $signed({1'b0, bus.x}) - $signed({1'b0, player_x_q});
        dy_s     = $signed({1'b0, bus.y}) - $signed({1'b0, player_y_q});
        in_box_s = (dx_s >= X_LO) && (dx_s <= X_HI) && (dy_s >= Y_LO) && (dy_s <= Y_HI);
        ox_s     = $unsigned(dx_s - X_LO);
        oy_s     = $unsigned(dy_s - Y_LO);
`ifdef PLAYER_BLINK_EN
        blink_mask_s = (state_q == ST_INVULN) && inv_cnt_q[2];
`else
        blink_mask_s = 1'b0;
`endif
        if (in_box_s) begin
            bus.sprite_addr = ox_s + oy_s * 11'(SPR_W);
        end else begin
            bus.sprite_addr = 11'd0;
        end
        bus.player_on = in_box_s && !blink_mask_s;
    end

    assign bus.player_x   = player_x_q;
    assign bus.player_y   = player_y_q;
    assign bus.lives      = lives_q;
    assign bus.state      = state_q;
    assign bus.game_over  = game_over_q;
    assign bus.sprite_sel = sprite_sel_q;
endmodule

// File: tb/tb_player_ctrl.sv
// Directed, table-driven bench for player_ctrl (TICK_DIV=4, INVULN_TICKS=5).
module tb_player_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    player_ctrl_if bus ();

    player_ctrl #(.TICK_DIV(4), .INVULN_TICKS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic up, down, left, right, slow;
        int   ex, ey;
    } move_vec_t;

    typedef struct {
        int sx, sy;
        int on;
        int addr;
    } spr_vec_t;

    move_vec_t mv[8];
    spr_vec_t  sv[8];
    int        blink_on;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic u, input logic d, input logic l, input logic r, input logic s);
        bus.ctrl_up = u; bus.ctrl_down = d; bus.ctrl_left = l; bus.ctrl_right = r; bus.ctrl_slow = s;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        mv[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 194, 400};
        mv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 190, 400};
        mv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 192, 398};
        mv[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 192, 401};
        mv[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 191, 400};
        mv[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 192, 398};
        mv[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 194, 402};
        mv[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 192, 400};
        sv[0] = '{177, 377, 1, 0};
        sv[1] = '{176, 377, 0, 0};
        sv[2] = '{208, 424, 1, 1535};
        sv[3] = '{209, 424, 0, 0};
        sv[4] = '{208, 425, 0, 0};
        sv[5] = '{192, 400, 1, 751};
        sv[6] = '{177, 376, 0, 0};
        sv[7] = '{200, 380, 1, 119};
`ifdef PLAYER_BLINK_EN
        blink_on = 0;
`else
        blink_on = 1;
`endif
        bus.x = 10'd0; bus.y = 10'd0; bus.collision = 1'b0;
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset state
        do_reset();
        check("rst_x", bus.player_x, 192);
        check("rst_y", bus.player_y, 400);
        check("rst_lives", bus.lives, 3);
        check("rst_state", bus.state, 0);
        check("rst_game_over", bus.game_over, 0);
        check("rst_sprite_sel", bus.sprite_sel, 0);

        // sprite box table with player at spawn
        for (int i = 0; i < 8; i++) begin
            bus.x = 10'(sv[i].sx); bus.y = 10'(sv[i].sy);
            #1;
            check($sformatf("spr_on[%0d]", i), bus.player_on, sv[i].on);
            check($sformatf("spr_addr[%0d]", i), bus.sprite_addr, sv[i].addr);
        end

        // one-tick moves from spawn
        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_ctrl(mv[i].up, mv[i].down, mv[i].left, mv[i].right, mv[i].slow);
            step(4);
            check($sformatf("move_x[%0d]", i), bus.player_x, mv[i].ex);
            check($sformatf("move_y[%0d]", i), bus.player_y, mv[i].ey);
            set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // tick cadence: one 2-pixel step every 4 cycles
        do_reset();
        bus.ctrl_right = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check($sformatf("cadence_x[%0d]", k), bus.player_x, 192 + 2 * (k / 4));
        end
        bus.ctrl_right = 1'b0;

        // saturation at all four edges
        do_reset();
        bus.ctrl_left = 1'b1;
        step(95 * 4);
        check("sat_left_2", bus.player_x, 2);
        bus.ctrl_slow = 1'b1;
        step(4);
        check("sat_left_1", bus.player_x, 1);
        bus.ctrl_slow = 1'b0;
        step(4);
        check("sat_left_0", bus.player_x, 0);
        step(4);
        check("sat_left_hold", bus.player_x, 0);
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(191 * 4);
        check("sat_right_382", bus.player_x, 382);
        step(4);
        check("sat_right_383", bus.player_x, 383);
        step(4);
        check("sat_right_hold", bus.player_x, 383);
        set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(23 * 4);
        check("sat_down_446", bus.player_y, 446);
        step(4);
        check("sat_down_447", bus.player_y, 447);
        step(4);
        check("sat_down_hold", bus.player_y, 447);
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(224 * 4);
        check("sat_up_0", bus.player_y, 0);
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // hit on the same edge as a tick
        do_reset();
        bus.ctrl_right = 1'b1;
        step(3);
        bus.collision = 1'b1;
        step(1);
        check("hit_tick_x", bus.player_x, 194);
        check("hit_tick_state", bus.state, 1);
        check("hit_tick_lives", bus.lives, 2);
        bus.collision = 1'b0; bus.ctrl_right = 1'b0;

        // held collision costs one life; invulnerability then expires on the 5th tick
        do_reset();
        bus.x = 10'd192; bus.y = 10'd400;
        bus.collision = 1'b1;
        step(1);
        check("hold_lives", bus.lives, 2);
        check("hold_state", bus.state, 1);
        check("hold_sprite_sel", bus.sprite_sel, 1);
        check("hold_pos_x", bus.player_x, 192);
        step(4);
        check("blink_cnt4_on", bus.player_on, blink_on);
        step(3);
        check("blink_cnt3_on", bus.player_on, 1);
        step(2);
        bus.collision = 1'b0;
        check("hold10_lives", bus.lives, 2);
        step(9);
        check("invuln_tick4_state", bus.state, 1);
        step(1);
        check("invuln_tick5_state", bus.state, 0);
        check("invuln_sprite_sel", bus.sprite_sel, 0);

        // second and third hits, then DEAD
        bus.collision = 1'b1;
        step(1);
        bus.collision = 1'b0;
        check("hit2_lives", bus.lives, 1);
        check("hit2_state", bus.state, 1);
        step(19);
        check("hit2_recover", bus.state, 0);
        bus.collision = 1'b1;
        step(1);
        check("hit3_lives", bus.lives, 0);
        check("hit3_state", bus.state, 2);
        check("hit3_game_over", bus.game_over, 1);
        bus.ctrl_right = 1'b1;
        step(12);
        check("dead_x_frozen", bus.player_x, 192);
        check("dead_lives", bus.lives, 0);
        check("dead_state", bus.state, 2);
        bus.collision = 1'b0; bus.ctrl_right = 1'b0;
        do_reset();
        check("rst2_x", bus.player_x, 192);
        check("rst2_y", bus.player_y, 400);
        check("rst2_lives", bus.lives, 3);
        check("rst2_state", bus.state, 0);
        check("rst2_game_over", bus.game_over, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 Parameter FIELD_W, default 384, playfield width in pixels; x range 0..FIELD_W-1.
REQ-002 Parameter FIELD_H, default 448, playfield height in pixels; y range 0..FIELD_H-1.
REQ-003 Parameter START_X / START_Y, default 192 / 400, spawn position.
REQ-004 Parameter TICK_DIV, default 2000000, clk cycles per movement tick (>=2).
REQ-005 Parameter SPEED_FAST / SPEED_SLOW, default 2 / 1, pixels per tick.
REQ-006 Parameter SPR_W / SPR_H, default 32 / 48, sprite box size (even, SPR_W*SPR_H <= 2048).
REQ-007 Parameter LIVES, default 3 (1..7), lives at reset.
REQ-008 Parameter INVULN_TICKS, default 120 (1..255), invulnerability length in ticks.
REQ-009 clk  in  1  system clock; all logic on rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 x, y  in  10 each  current scan pixel.
REQ-012 ctrl_up, ctrl_down, ctrl_left, ctrl_right  in  1 each  direction buttons, level-sensitive.
REQ-013 ctrl_slow  in  1  focus mode; selects SPEED_SLOW.
REQ-014 collision  in  1  bullet-hit pulse/level from collision unit.
REQ-015 player_x, player_y  out  10 each  registered player centre.
REQ-016 lives  out  3  remaining lives.
REQ-017 state  out  2  00 ALIVE, 01 INVULN, 10 DEAD.
REQ-018 game_over  out  1  high while DEAD.
REQ-019 sprite_addr  out  11  sprite ROM address, combinational.
REQ-020 sprite_sel  out  1  1 selects hit sprite ROM (state INVULN).
REQ-021 player_on  out  1  scan pixel inside visible sprite box, combinational.

Function
REQ-022 Tick counter counts 0..TICK_DIV-1 and wraps; tick is a one-cycle pulse when count = TICK_DIV-1.
REQ-023 Movement only on tick and only in ALIVE or INVULN; step = SPEED_SLOW if ctrl_slow else SPEED_FAST.
REQ-024 up decreases y, down increases y, left decreases x, right increases x; up+down together or left+right together cancel on that axis; diagonals move both axes by the full step.
REQ-025 Position saturates: decrease below 0 yields 0, increase beyond FIELD_W-1 / FIELD_H-1 yields that limit; arithmetic done in 11 bits, no wrap.
REQ-026 ALIVE + collision (any cycle): lives decrements; if lives was 1 -> DEAD with lives=0, else -> INVULN with invuln counter = INVULN_TICKS; position unchanged by the hit.
REQ-027 INVULN: collision ignored; invuln counter decrements on each tick; on the tick where it reaches 0 -> ALIVE.
REQ-028 DEAD: position frozen, collision and controls ignored; only reset leaves DEAD.
REQ-029 Collision and tick in the same cycle: state transition and movement both take effect.
REQ-030 Collision held high for multiple cycles costs exactly one life (INVULN masks the rest).
REQ-031 Box: x in [player_x-SPR_W/2+1, player_x+SPR_W/2], y in [player_y-SPR_H/2+1, player_y+SPR_H/2], compared signed in 11 bits so boxes near 0 do not wrap.
REQ-032 In box: sprite_addr = (x-player_x+SPR_W/2-1) + (y-player_y+SPR_H/2-1)*SPR_W; outside box: 0.
REQ-033 player_on = in box, further masked per REQ-037; transparency keying is done by the downstream mixer.

Reset
REQ-034 On reset: player_x=START_X, player_y=START_Y, lives=LIVES, state=ALIVE, game_over=0, tick counter=0, invuln counter=0.
REQ-035 Reset mid-INVULN or in DEAD takes effect next edge; no tick or hit is processed in the reset cycle.

Configuration
REQ-036 Macro PLAYER_BLINK_EN selects invulnerability blinking.
REQ-037 Defined: in INVULN, player_on forced 0 while invuln counter bit 2 = 1; undefined: player_on never masked by state.

Verification
REQ-038 TICK_DIV=4, hold ctrl_right, no slow -> player_x 192,194,196 at ticks 1,2,3; tick pulses every 4 cycles.
REQ-039 player_x=1, ctrl_left, fast, one tick -> player_x=0; player_y=FIELD_H-2, ctrl_down -> FIELD_H-1.
REQ-040 ctrl_up+ctrl_down+ctrl_slow+ctrl_left one tick from (192,400) -> (191,400).
REQ-041 collision held 10 cycles in ALIVE, lives=3 -> lives=2, state=INVULN; INVULN_TICKS=5 -> ALIVE on 5th tick.
REQ-042 three separated hits -> lives=0, state=DEAD, game_over=1, controls ignored; reset -> (192,400), lives=3, ALIVE.
REQ-043 player at (192,400), scan (177,377) -> player_on=1, sprite_addr=0; scan (176,377) -> player_on=0; with PLAYER_BLINK_EN, INVULN counter=4 -> player_on=0.
